// File: rtl/regfile_gen.sv
// Parameterised register file with two combinational read ports, byte-enabled
// writes, optional write-to-read forwarding, a pending-result scoreboard and a
// sequential clear engine that sweeps one register per cycle.
module regfile_gen #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [ADDR_W-1:0]   raddr_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  input  logic                pend_set,
  input  logic [ADDR_W-1:0]   pend_addr,
  output logic                pend_a,
  output logic                pend_b,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic                idx_last;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    pending;
  logic                wr_acc;
  logic                hit_a;
  logic                hit_b;

  // Replace only the byte lanes selected by be.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [NBYTES-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_val;
    for (int k = 0; k < NBYTES; k++) begin
      if (be[k]) r[8*k +: 8] = new_val[8*k +: 8];
    end
    return r;
  endfunction

  // True for the hardwired-zero location when that option is enabled.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes are refused while the clear engine owns the array.
  assign wr_acc   = we & ~clr_busy;
  assign idx_last = (idx == ADDR_W'(DEPTH - 1));

  // Clear FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Clear FSM next-state logic; clr_start is only heard in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (idx_last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    clr_busy = (state == CLEAR);
    clr_done = (state == DONE);
  end

  // Sweep index: restarts at 0 on a new clear, walks up while clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             idx <= '0;
    else if (state == IDLE && clr_start) idx <= '0;
    else if (state == CLEAR && !idx_last) idx <= idx + ADDR_W'(1);
  end

  // Register array: byte-enabled writes, with the sweep zeroing one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_acc && !is_zero_reg(waddr)) regs[waddr] <= byte_merge(regs[waddr], wdata, wbe);
      if (clr_busy) regs[idx] <= '0;
    end
  end

  // Scoreboard: write clears, set overrides write, sweep overrides set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wr_acc) pending[waddr] <= 1'b0;
      if (pend_set && !is_zero_reg(pend_addr)) pending[pend_addr] <= 1'b1;
      if (clr_busy) pending[idx] <= 1'b0;
    end
  end

  // Read port A with optional forwarding of the in-flight write.
  always_comb begin
    hit_a   = (BYPASS != 0) && wr_acc && (waddr == raddr_a);
    rdata_a = regs[raddr_a];
    if (hit_a) rdata_a = byte_merge(regs[raddr_a], wdata, wbe);
    if (is_zero_reg(raddr_a)) rdata_a = '0;
    pend_a  = pending[raddr_a] & ~(hit_a & ~(pend_set & (pend_addr == raddr_a)));
  end

  // Read port B with optional forwarding of the in-flight write.
  always_comb begin
    hit_b   = (BYPASS != 0) && wr_acc && (waddr == raddr_b);
    rdata_b = regs[raddr_b];
    if (hit_b) rdata_b = byte_merge(regs[raddr_b], wdata, wbe);
    if (is_zero_reg(raddr_b)) rdata_b = '0;
    pend_b  = pending[raddr_b] & ~(hit_b & ~(pend_set & (pend_addr == raddr_b)));
  end

endmodule

// File: tb/tb_regfile_gen.sv
// Bench for regfile_gen: a forwarding instance and a non-forwarding instance
// share one stimulus stream and are compared against an array-based model.
module tb_regfile_gen;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic        clr_start;

  logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic        pend_a0, pend_b0, pend_a1, pend_b1;
  logic        busy0, done0, busy1, done1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mem [32];
  bit          pnd [32];
  bit          busy_m;
  bit          done_m;
  int          ci;

  regfile_gen #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a0), .rdata_b(rdata_b0),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(pend_a0), .pend_b(pend_b0),
    .clr_start(clr_start), .clr_busy(busy0), .clr_done(done0));

  regfile_gen #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a1), .rdata_b(rdata_b1),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(pend_a1), .pend_b(pend_b1),
    .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] be_mask();
    return {{8{wbe[3]}}, {8{wbe[2]}}, {8{wbe[1]}}, {8{wbe[0]}}};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && !busy_m && waddr == a) return (mem[a] & ~be_mask()) | (wdata & be_mask());
    return mem[a];
  endfunction

  function automatic logic [31:0] exp_pd(input logic [4:0] a, input bit byp);
    if (byp && we && !busy_m && waddr == a && !(pend_set && pend_addr == a)) return 32'h0;
    return {31'h0, pnd[a]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h0;
      pnd[i] = 1'b0;
    end
    busy_m = 1'b0;
    done_m = 1'b0;
    ci     = 0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    if (we && !busy_m) begin
      if (waddr != 5'd0) mem[waddr] = (mem[waddr] & ~be_mask()) | (wdata & be_mask());
      pnd[waddr] = 1'b0;
    end
    if (pend_set && pend_addr != 5'd0) pnd[pend_addr] = 1'b1;
    if (busy_m) begin
      mem[ci] = 32'h0;
      pnd[ci] = 1'b0;
    end
    if (done_m) done_m = 1'b0;
    else if (busy_m) begin
      if (ci == 31) begin
        busy_m = 1'b0;
        done_m = 1'b1;
      end else ci++;
    end else if (clr_start) begin
      busy_m = 1'b1;
      ci     = 0;
    end
  endtask

  task automatic check_all();
    chk("u0_rdata_a", rdata_a0, exp_rd(raddr_a, 1'b1));
    chk("u0_rdata_b", rdata_b0, exp_rd(raddr_b, 1'b1));
    chk("u1_rdata_a", rdata_a1, exp_rd(raddr_a, 1'b0));
    chk("u1_rdata_b", rdata_b1, exp_rd(raddr_b, 1'b0));
    chk("u0_pend_a", {31'h0, pend_a0}, exp_pd(raddr_a, 1'b1));
    chk("u0_pend_b", {31'h0, pend_b0}, exp_pd(raddr_b, 1'b1));
    chk("u1_pend_a", {31'h0, pend_a1}, exp_pd(raddr_a, 1'b0));
    chk("u1_pend_b", {31'h0, pend_b1}, exp_pd(raddr_b, 1'b0));
    chk("u0_busy", {31'h0, busy0}, {31'h0, busy_m});
    chk("u1_busy", {31'h0, busy1}, {31'h0, busy_m});
    chk("u0_done", {31'h0, done0}, {31'h0, done_m});
    chk("u1_done", {31'h0, done1}, {31'h0, done_m});
  endtask

  // Check combinational outputs before the edge, then advance model and DUT.
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    we        = 1'b0;
    pend_set  = 1'b0;
    clr_start = 1'b0;
    wbe       = 4'hF;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_in();
    we    = 1'b1;
    waddr = a;
    wdata = d;
    wbe   = be;
    tick();
    we = 1'b0;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst = 1'b1;
    idle_in();
    waddr = '0; wdata = '0; raddr_a = 5'd3; raddr_b = 5'd17; pend_addr = '0;
    model_reset();
    @(posedge clk);
    #1;
    // Reset state
    chk("rst_rdata_a", rdata_a0, 32'h0);
    chk("rst_rdata_b", rdata_b1, 32'h0);
    chk("rst_pend", {31'h0, pend_a0 | pend_b0 | pend_a1 | pend_b1}, 32'h0);
    chk("rst_busy", {31'h0, busy0 | busy1}, 32'h0);
    chk("rst_done", {31'h0, done0 | done1}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Zero data is written like any other value
    wr(5'd3, 32'hDEADBEEF, 4'hF);
    wr(5'd3, 32'h00000000, 4'hF);
    raddr_a = 5'd3; #1;
    chk("zero_write", rdata_a0, 32'h00000000);
    tick();

    // Byte enables
    wr(5'd5, 32'h11223344, 4'hF);
    wr(5'd5, 32'hAABBCCDD, 4'b0101);
    raddr_b = 5'd5; #1;
    chk("byte_en", rdata_b0, 32'h11BB33DD);
    tick();

    // Forwarding versus registered read
    wr(5'd7, 32'h00001234, 4'hF);
    raddr_a = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h5; wbe = 4'hF; #1;
    chk("bypass_on", rdata_a0, 32'h5);
    chk("bypass_off", rdata_a1, 32'h00001234);
    tick();
    we = 1'b0; #1;
    chk("bypass_off_after", rdata_a1, 32'h5);

    // Register 0 hardwired to zero, never pending
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    pend_set = 1'b1; pend_addr = 5'd0; tick(); pend_set = 1'b0;
    raddr_a = 5'd0; #1;
    chk("zero_reg_data", rdata_a0, 32'h0);
    chk("zero_reg_pend", {31'h0, pend_a0}, 32'h0);

    // Scoreboard
    raddr_a = 5'd9;
    pend_set = 1'b1; pend_addr = 5'd9; tick(); pend_set = 1'b0; #1;
    chk("pend_set_r9", {31'h0, pend_a0}, 32'h1);
    we = 1'b1; waddr = 5'd9; wdata = 32'h99; wbe = 4'h0; #1;
    chk("pend_fwd_clear", {31'h0, pend_a0}, 32'h0);
    chk("pend_nofwd_hold", {31'h0, pend_a1}, 32'h1);
    tick(); we = 1'b0; #1;
    chk("pend_cleared_wbe0", {31'h0, pend_a1}, 32'h0);
    we = 1'b1; pend_set = 1'b1; pend_addr = 5'd9; wbe = 4'hF; tick();
    idle_in(); #1;
    chk("pend_set_wins", {31'h0, pend_a0}, 32'h1);
    tick();

    // Randomized traffic, including occasional clears
    for (int n = 0; n < 400; n++) begin
      we        = ($urandom_range(0, 2) != 0);
      waddr     = 5'($urandom);
      wdata     = $urandom;
      wbe       = 4'($urandom);
      raddr_a   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr_b   = 5'($urandom);
      pend_set  = ($urandom_range(0, 3) == 0);
      pend_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      clr_start = ($urandom_range(0, 60) == 0);
      tick();
    end
    idle_in();
    for (int n = 0; n < 40; n++) tick();

    // Full clear with dropped writes during the sweep
    for (int i = 0; i < 32; i++) wr(5'(i), $urandom | 32'h1, 4'hF);
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
      we        = busy_m;
      waddr     = 5'($urandom);
      wdata     = $urandom | 32'h1;
      wbe       = 4'hF;
      clr_start = busy_m && ($urandom_range(0, 4) == 0);
      raddr_a   = 5'($urandom);
      raddr_b   = 5'($urandom);
      tick();
    end
    idle_in();
    chk("clr_busy_cycles", busy_cnt, 32);
    chk("clr_done_pulses", done_cnt, 1);
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i); #1;
      chk("cleared_a", rdata_a0, 32'h0);
      chk("cleared_b", rdata_b1, 32'h0);
    end
    tick();

    // Reset in the middle of a clear
    for (int i = 0; i < 32; i++) wr(5'(i), $urandom | 32'h100, 4'hF);
    pend_set = 1'b1; pend_addr = 5'd20; tick(); pend_set = 1'b0;
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    raddr_a = 5'd20; raddr_b = 5'd25; #1;
    chk("preclr_busy", {31'h0, busy0}, 32'h1);
    rst = 1'b1; #1;
    model_reset();
    chk("midrst_rdata_a", rdata_a0, 32'h0);
    chk("midrst_rdata_b", rdata_b0, 32'h0);
    chk("midrst_pend", {31'h0, pend_a0 | pend_a1}, 32'h0);
    chk("midrst_busy", {31'h0, busy0 | busy1}, 32'h0);
    chk("midrst_done", {31'h0, done0 | done1}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      raddr_a = 5'($urandom); raddr_b = 5'($urandom);
      if (done0 || done1) done_cnt++;
      tick();
    end
    chk("midrst_no_done", done_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_gen.md
REGFILE_GEN -- requirements
Module: regfile_gen

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the register width in bits, a multiple of 8.
REQ-002 The module SHALL have parameter ADDR_W, default 5, giving DEPTH = 2^ADDR_W registers.
REQ-003 The module SHALL have parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero, never pending.
REQ-004 The module SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding.
REQ-005 The module SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 The module SHALL have port we, input, 1, write enable.
REQ-008 The module SHALL have port waddr, input, ADDR_W, write address.
REQ-009 The module SHALL have port wdata, input, DATA_W, write data.
REQ-010 The module SHALL have port wbe, input, DATA_W/8, byte enables; bit k covers wdata[8k+7:8k].
REQ-011 The module SHALL have ports raddr_a and raddr_b, input, ADDR_W each, read addresses.
REQ-012 The module SHALL have ports rdata_a and rdata_b, output, DATA_W each, combinational read data.
REQ-013 The module SHALL have ports pend_set (input, 1) and pend_addr (input, ADDR_W), which mark a register as pending (result outstanding).
REQ-014 The module SHALL have ports pend_a and pend_b, output, 1 each, giving the pending status of raddr_a and raddr_b.
REQ-015 The module SHALL have port clr_start, input, 1, a request for a sequential clear of all registers.
REQ-016 The module SHALL have ports clr_busy (output, 1), high while clearing, and clr_done (output, 1), a one-cycle completion pulse.

Function
REQ-017 A write SHALL occur when we=1 and clr_busy=0; only bytes with wbe[k]=1 are updated.
REQ-018 Zero data SHALL be written like any other value; no write is suppressed on data value.
REQ-019 When ZERO_REG=1, writes to address 0 SHALL be discarded, and reads of address 0 SHALL return 0.
REQ-020 When we=1 and clr_busy=1, the write SHALL be dropped entirely: no data update and no pending clear.
REQ-021 When BYPASS=1 and an accepted write targets raddr_x (not hardwired zero), rdata_x SHALL equal the stored value with enabled bytes replaced by wdata, in the same cycle.
REQ-022 When BYPASS=0, rdata_x SHALL show the pre-write stored value until the edge after the write.
REQ-023 pend_set=1 SHALL set pending[pend_addr] at the clock edge; it is ignored for address 0 when ZERO_REG=1.
REQ-024 An accepted write SHALL clear pending[waddr] regardless of wbe, including wbe=0.
REQ-025 When pend_set and an accepted write hit the same address in the same cycle, set SHALL win and the bit ends at 1.
REQ-026 pend_x SHALL equal pending[raddr_x]; when BYPASS=1 it is forced 0 if an accepted write targets raddr_x that cycle and pend_set does not target the same address.
REQ-027 The clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-028 In IDLE, clr_start=1 SHALL move the FSM to CLEAR with index = 0.
REQ-029 In CLEAR, each cycle SHALL zero register[index] and pending[index]; the FSM moves to DONE when index = DEPTH-1, otherwise index increments; clearing takes exactly DEPTH cycles.
REQ-030 In DONE, clr_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-031 clr_busy SHALL be 1 exactly while in CLEAR.
REQ-032 clr_start SHALL be ignored in CLEAR and DONE; it is not queued.
REQ-033 pend_set in CLEAR SHALL still apply, except at the address being cleared that cycle, where clear wins.
REQ-034 Reads during CLEAR SHALL return current stored contents, whether already cleared or not.

Reset
REQ-035 While rst=1, all registers SHALL be 0, all pending bits 0, FSM in IDLE, index 0, clr_busy=0 and clr_done=0.
REQ-036 rst asserted mid-CLEAR SHALL abort the clear immediately with no clr_done pulse.

Verification
REQ-037 Verify zero write: write 0xDEADBEEF to r3, then write 0x00000000 with wbe=4'hF -> r3 reads 0x00000000.
REQ-038 Verify byte enables: r5 = 0x11223344, write 0xAABBCCDD with wbe=4'b0101 -> r5 = 0x11BB33DD.
REQ-039 Verify bypass (BYPASS=1): raddr_a=7 with we=1, waddr=7, wdata=0x5 in the same cycle -> rdata_a=0x5 before the edge; with BYPASS=0 -> old value.
REQ-040 Verify scoreboard: pend_set r9 -> pend_a=1 at raddr_a=9; write r9 -> pend_a=0; simultaneous set and write to r9 -> pend_a=1.
REQ-041 Verify clear: fill all registers, pulse clr_start -> clr_busy high 32 cycles (ADDR_W=5), all registers 0, clr_done one cycle; a we during busy is dropped.
REQ-042 Verify reset mid-clear: assert rst at clear cycle 10 -> all outputs 0 at once, no clr_done, FSM IDLE.
